// File: rtl/tq_transpose_buf_if.sv
// Row-in / column-out bus of the transpose buffer: row-pass results in, column-pass operands out.
// Lane k of i_data is column k of a row; lane k of o_data is row k of a column.
interface tq_transpose_buf_if;
    logic              i_valid;
    logic              i_inverse;
    logic [1:0]        i_transize;
    logic [31:0][15:0] i_data;

    logic              o_valid;
    logic              o_row;
    logic              o_inverse;
    logic [1:0]        o_transize;
    logic [31:0][15:0] o_data;
    logic              o_err;

    modport master (
        output i_valid, i_inverse, i_transize, i_data,
        input  o_valid, o_row, o_inverse, o_transize, o_data, o_err
    );

    modport slave (
        input  i_valid, i_inverse, i_transize, i_data,
        output o_valid, o_row, o_inverse, o_transize, o_data, o_err
    );
endinterface

// File: rtl/tq_transpose_buf.sv
// Ping-pong N x N transpose buffer (N = 4/8/16/32): rows in, columns out one per cycle, 1 cycle after the last row.
// No backpressure: rows arriving while the write bank is still occupied are dropped and o_err sticks high.
module tq_transpose_buf (
    input  logic              clk,
    input  logic              rst,
    tq_transpose_buf_if.slave bus
);
    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_FILLING  = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_DRAINING = 2'd3;

    logic [1:0]        bank_st  [2];
    logic [1:0]        bank_sz  [2];
    logic              bank_inv [2];
    logic              wb;
    logic              rb;
    logic [4:0]        wr;
    logic [4:0]        rc;
    logic [31:0][15:0] mem [2][32];

    logic              wr_open;
    logic              wr_ok;
    logic              wr_last;
    logic [1:0]        wsz;
    logic              rd_act;
    logic              rd_last;
    logic [5:0]        rd_n;
    logic [31:0][15:0] col;

    function automatic logic [5:0] blk_n(input logic [1:0] sz);
        return 6'd4 << sz;
    endfunction

    always_comb begin
        wr_open = (bank_st[wb] == ST_EMPTY) || (bank_st[wb] == ST_FILLING);
        wr_ok   = bus.i_valid && wr_open;
        // The block size is only known from the live input on its first row.
        wsz     = (wr == 5'd0) ? bus.i_transize : bank_sz[wb];
        wr_last = ({1'b0, wr} == (blk_n(wsz) - 6'd1));
        rd_act  = (bank_st[rb] == ST_FULL) || (bank_st[rb] == ST_DRAINING);
        rd_n    = blk_n(bank_sz[rb]);
        rd_last = ({1'b0, rc} == (rd_n - 6'd1));
        col     = '0;
        for (int k = 0; k < 32; k++) begin
            if (6'(k) < rd_n) begin
                col[k] = mem[rb][k][rc];
            end
        end
    end

    // Storage is deliberately left out of reset; a bank is only read once fully rewritten.
    always_ff @(posedge clk) begin
        if (wr_ok && rst) begin
            mem[wb][wr] <= bus.i_data;
        end
    end

    // Write and read never touch the same bank on one edge: their bank states are disjoint.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b]  <= ST_EMPTY;
                bank_sz[b]  <= 2'd0;
                bank_inv[b] <= 1'b0;
            end
            wb             <= 1'b0;
            rb             <= 1'b0;
            wr             <= 5'd0;
            rc             <= 5'd0;
            bus.o_valid    <= 1'b0;
            bus.o_data     <= '0;
            bus.o_transize <= 2'd0;
            bus.o_inverse  <= 1'b0;
            bus.o_err      <= 1'b0;
        end else begin
            if (wr_ok) begin
                if (wr == 5'd0) begin
                    bank_sz[wb]  <= bus.i_transize;
                    bank_inv[wb] <= bus.i_inverse;
                end
                if (wr_last) begin
                    bank_st[wb] <= ST_FULL;
                    wr          <= 5'd0;
                    wb          <= ~wb;
                end else begin
                    bank_st[wb] <= ST_FILLING;
                    wr          <= wr + 5'd1;
                end
            end

            if (rd_act) begin
                if (rd_last) begin
                    bank_st[rb] <= ST_EMPTY;
                    rc          <= 5'd0;
                    rb          <= ~rb;
                end else begin
                    bank_st[rb] <= ST_DRAINING;
                    rc          <= rc + 5'd1;
                end
            end

            if (bus.i_valid && !wr_open) begin
                bus.o_err <= 1'b1;
            end

            bus.o_valid <= rd_act;
            bus.o_data  <= rd_act ? col : '0;
            if (rd_act) begin
                bus.o_transize <= bank_sz[rb];
                bus.o_inverse  <= bank_inv[rb];
            end
        end
    end

    assign bus.o_row = 1'b0;
endmodule

// File: tb/tb_tq_transpose_buf.sv
// Bench for tq_transpose_buf: hand-computed vector table, directed corner sequences and random blocks
// checked every cycle against a block/timeline model of the ping-pong buffer.
module tb_tq_transpose_buf;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tq_transpose_buf_if bus();
    tq_transpose_buf dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int vld_cnt = 0;
    int runs    = 0;
    logic prev_vld = 1'b0;

    // Model: blocks are numbered in arrival order and alternate banks; each block drains
    // as soon as it is complete and its predecessor has finished draining.
    logic [15:0]       mblk [4][32][32];
    int                mstart [4];
    int                mend   [4];
    int                mn     [4];
    logic [1:0]        msz    [4];
    logic              minv   [4];
    int                nblk;
    int                fill_cnt;
    logic              m_err;
    logic [1:0]        m_otsz;
    logic              m_oinv;
    logic              e_vld;
    logic [31:0][15:0] e_dat;

    typedef struct {
        logic [1:0] tsz;
        logic       inv;
        int         mul;
        int         pcol;
        int         plane;
        int         exp_cols;
        int         exp_val;
    } vec_t;

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        nblk = 0; fill_cnt = 0; m_err = 1'b0; m_otsz = 2'd0; m_oinv = 1'b0;
    endtask

    task automatic model_edge();
        int j;
        int col;
        j = nblk % 4;
        if (bus.i_valid) begin
            if (fill_cnt == 0) begin
                if (nblk < 2 || cyc > mend[(nblk - 2) % 4]) begin
                    msz[j]  = bus.i_transize;
                    minv[j] = bus.i_inverse;
                    mn[j]   = 4 << bus.i_transize;
                    for (int c = 0; c < 32; c++) mblk[j][0][c] = bus.i_data[c];
                    fill_cnt = 1;
                end else begin
                    m_err = 1'b1;
                end
            end else begin
                for (int c = 0; c < 32; c++) mblk[j][fill_cnt][c] = bus.i_data[c];
                fill_cnt++;
                if (fill_cnt == mn[j]) begin
                    mstart[j] = cyc + 1;
                    if (nblk > 0 && mend[(nblk - 1) % 4] + 1 > mstart[j])
                        mstart[j] = mend[(nblk - 1) % 4] + 1;
                    mend[j] = mstart[j] + mn[j] - 1;
                    nblk++;
                    fill_cnt = 0;
                end
            end
        end
        e_vld = 1'b0;
        e_dat = '0;
        for (int b = (nblk > 3) ? nblk - 3 : 0; b < nblk; b++) begin
            j = b % 4;
            if (cyc >= mstart[j] && cyc <= mend[j]) begin
                e_vld  = 1'b1;
                col    = cyc - mstart[j];
                m_otsz = msz[j];
                m_oinv = minv[j];
                for (int k = 0; k < 32; k++)
                    if (k < mn[j]) e_dat[k] = mblk[j][k][col];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("o_valid", bus.o_valid, e_vld);
        chk("o_err", bus.o_err, m_err);
        chk("o_row", bus.o_row, 1'b0);
        if (e_vld) begin
            chk("o_data", bus.o_data, e_dat);
            chk("o_transize", bus.o_transize, m_otsz);
            chk("o_inverse", bus.o_inverse, m_oinv);
        end
        if (bus.o_valid) vld_cnt++;
        if (bus.o_valid && !prev_vld) runs++;
        prev_vld = bus.o_valid;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, " o_valid"}, bus.o_valid, 1'b0);
        chk({nm, " o_data"}, bus.o_data, 512'd0);
        chk({nm, " o_err"}, bus.o_err, 1'b0);
        chk({nm, " o_transize"}, bus.o_transize, 2'd0);
        chk({nm, " o_inverse"}, bus.o_inverse, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        bus.i_valid = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst_async");
        repeat (n) begin
            @(posedge clk);
            #1;
            check_reset_outputs("rst_hold");
            cyc++;
        end
        prev_vld = 1'b0;
        rst = 1'b1;
    endtask

    task automatic drive_row(input logic [1:0] tsz, input logic inv, input int r, input int mode, input int mul);
        int v;
        bus.i_valid    = 1'b1;
        bus.i_transize = tsz;
        bus.i_inverse  = inv;
        for (int c = 0; c < 32; c++) begin
            case (mode)
                0:       v = mul * r + c;
                1:       v = ((r + c) % 2 != 0) ? 32767 : -32768;
                default: v = int'($urandom);
            endcase
            bus.i_data[c] = 16'(v);
        end
    endtask

    task automatic idle(input int n);
        bus.i_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_block(input logic [1:0] tsz, input logic inv, input int mode, input int mul, input int gap);
        for (int r = 0; r < (4 << tsz); r++) begin
            drive_row(tsz, inv, r, mode, mul);
            tick();
            if (gap > 0) idle($urandom_range(0, gap));
        end
        bus.i_valid = 1'b0;
    endtask

    vec_t vecs [5];

    initial begin
        int cols, first, got_val, got_hi, n, v0, r0;
        logic [1:0] got_tsz;
        logic got_inv;

        vecs[0] = '{tsz: 2'd0, inv: 1'b0, mul: 16,    pcol: 3,  plane: 2,  exp_cols: 4,  exp_val: 35};
        vecs[1] = '{tsz: 2'd1, inv: 1'b1, mul: 16,    pcol: 7,  plane: 5,  exp_cols: 8,  exp_val: 87};
        vecs[2] = '{tsz: 2'd2, inv: 1'b0, mul: 100,   pcol: 10, plane: 15, exp_cols: 16, exp_val: 1510};
        vecs[3] = '{tsz: 2'd3, inv: 1'b1, mul: 32,    pcol: 31, plane: 31, exp_cols: 32, exp_val: 1023};
        vecs[4] = '{tsz: 2'd3, inv: 1'b0, mul: -1000, pcol: 0,  plane: 31, exp_cols: 32, exp_val: -31000};

        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_inverse = 1'b0; bus.i_transize = 2'd0; bus.i_data = '0;
        model_reset();
        #2;
        do_reset(3);

        // Single blocks: latency, column count, latched size/direction, one transposed sample.
        for (int i = 0; i < 5; i++) begin
            send_block(vecs[i].tsz, vecs[i].inv, 0, vecs[i].mul, 0);
            n = 4 << vecs[i].tsz;
            cols = 0; first = -1; got_val = 0; got_hi = 0; got_tsz = 2'd0; got_inv = 1'b0;
            for (int t = 0; t < 40; t++) begin
                tick();
                if (bus.o_valid) begin
                    if (first < 0) begin
                        first = t; got_tsz = bus.o_transize; got_inv = bus.o_inverse;
                    end
                    if (cols == vecs[i].pcol) begin
                        got_val = int'($signed(bus.o_data[vecs[i].plane]));
                        if (n < 32) got_hi = int'($signed(bus.o_data[n]));
                    end
                    cols++;
                end
            end
            chk_int("tbl latency", first, 0);
            chk_int("tbl columns", cols, vecs[i].exp_cols);
            chk_int("tbl sample", got_val, vecs[i].exp_val);
            chk("tbl o_transize", got_tsz, vecs[i].tsz);
            chk("tbl o_inverse", got_inv, vecs[i].inv);
            if (n < 32) chk_int("tbl lane>=N", got_hi, 0);
        end

        // Two back-to-back 32x32 blocks drain as one gapless 64-cycle run.
        v0 = vld_cnt; r0 = runs;
        send_block(2'd3, 1'b0, 0, 32, 0);
        send_block(2'd3, 1'b1, 2, 0, 0);
        idle(80);
        chk_int("b2b32 valid cycles", vld_cnt - v0, 64);
        chk_int("b2b32 runs", runs - r0, 1);
        chk("b2b32 o_err", bus.o_err, 1'b0);

        // 32x32 then three 4x4: first buffered, the rest dropped while both banks busy.
        v0 = vld_cnt; r0 = runs;
        send_block(2'd3, 1'b0, 2, 0, 0);
        send_block(2'd0, 1'b1, 0, 16, 0);
        send_block(2'd0, 1'b0, 0, 16, 0);
        send_block(2'd0, 1'b1, 0, 16, 0);
        idle(60);
        chk_int("ovf valid cycles", vld_cnt - v0, 36);
        chk_int("ovf runs", runs - r0, 1);
        chk("ovf o_err", bus.o_err, 1'b1);
        v0 = vld_cnt;
        send_block(2'd0, 1'b0, 0, 16, 0);
        idle(10);
        chk_int("post-ovf accepted", vld_cnt - v0, 4);
        chk("ovf o_err sticky", bus.o_err, 1'b1);
        do_reset(2);

        // Size and direction toggled mid-block are ignored.
        v0 = vld_cnt;
        for (int r = 0; r < 8; r++) begin
            drive_row((r == 0 || r % 2 == 0) ? 2'd1 : 2'd3, (r < 3) ? 1'b1 : 1'b0, r, 0, 8);
            tick();
        end
        idle(14);
        chk_int("toggle columns", vld_cnt - v0, 8);
        chk("toggle o_transize", bus.o_transize, 2'd1);
        chk("toggle o_inverse", bus.o_inverse, 1'b1);

        // Reset in the middle of a 16x16 block; a fresh 8x8 block must come out alone.
        for (int r = 0; r < 5; r++) begin
            drive_row(2'd2, 1'b1, r, 0, 50);
            tick();
        end
        do_reset(3);
        v0 = vld_cnt; r0 = runs;
        send_block(2'd1, 1'b0, 0, 3, 0);
        idle(14);
        chk_int("post-rst columns", vld_cnt - v0, 8);
        chk_int("post-rst runs", runs - r0, 1);

        // Full-scale alternating values keep their signs.
        send_block(2'd2, 1'b0, 1, 0, 0);
        bus.i_valid = 1'b0;
        tick();
        chk("fullscale lane0", bus.o_data[0], 16'h8000);
        chk("fullscale lane1", bus.o_data[1], 16'h7fff);
        idle(20);

        // Random sizes, gaps and data against the model.
        for (int b = 0; b < 40; b++) begin
            send_block(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2, 0,
                       ($urandom_range(0, 2) == 0) ? 2 : 0);
            idle($urandom_range(0, 4));
        end
        idle(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tq_transpose_buf.md
# tq_transpose_buf

Ping-pong transpose buffer between the row (first) pass and the column (second) pass of the 2-D forward/inverse transform. It accepts one 32-lane row per valid cycle from the row-pass `o_*` outputs and stores a complete N×N block (N = 4/8/16/32). It then replays the block column by column, one column per cycle, into the column-pass `i_*` inputs with row = 0. Two banks let the next block be written while the previous one drains.

## Interface
- No parameters. Sizes are fixed: 32 lanes, 16-bit signed data, 2 banks of 32×32 entries.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- i_valid  in  1  row present on i_0..i_31 this cycle
- i_inverse  in  1  transform direction; sampled on the first row of a block
- i_transize  in  2  block size: 0→4, 1→8, 2→16, 3→32; sampled on the first row of a block
- i_0..i_31  in  16 each, signed  row samples; lane k = column k; lanes ≥ N ignored
- o_valid  out  1  column present on o_0..o_31
- o_row  out  1  constant 0 (marks the column pass for the downstream transform)
- o_inverse  out  1  latched direction of the draining block
- o_transize  out  2  latched size of the draining block
- o_0..o_31  out  16 each, signed  column samples; lane k = row k; lanes ≥ N driven 0
- o_err  out  1  sticky overflow flag; cleared only by rst

## Operation
- Each bank has a state: EMPTY, FILLING, FULL or DRAINING, plus its own latched N and inverse.
- Write side:
  - Write bank pointer `wb` and row counter `wr` (0..N-1).
  - When i_valid is high and bank[wb] is EMPTY or FILLING, the row is stored at row index `wr`.
  - On `wr` = 0, the bank latches i_transize and i_inverse and moves to FILLING. Mid-block changes to either input are ignored.
  - On `wr` = N-1, the bank moves to FULL, `wr` resets to 0 and `wb` toggles.
  - When i_valid is high and bank[wb] is FULL or DRAINING, the row is dropped, o_err is set to 1, and `wr` and `wb` are unchanged.
- Read side:
  - Read bank pointer `rb` and column counter `rc` (0..N-1).
  - When bank[rb] is FULL or DRAINING, column `rc` is emitted. A FULL bank moves to DRAINING.
  - On `rc` = N-1, the bank moves to EMPTY, `rc` resets to 0 and `rb` toggles.
  - Drain runs every cycle with no stall. A FULL second bank starts draining on the cycle right after the first bank's last column; there is no gap.
- Column output: o_k = stored[row k][column rc] for k < N, and 0 for k ≥ N.
- Arithmetic: pure data movement. No rounding, saturation or sign change. Values are bit-exact.
- Same-edge events:
  - A bank that reaches EMPTY on an edge may be written in the next cycle.
  - A write that completes bank[wb] on the same edge that the read side finishes the other bank: both transitions apply, and the new FULL bank drains starting the next cycle.
- Reset (at any time, including mid-block):
  - Both banks go to EMPTY; wb = rb = wr = rc = 0.
  - o_valid = 0, o_0..o_31 = 0, o_transize = 0, o_inverse = 0, o_row = 0, o_err = 0.
  - Stored data is not cleared and is never emitted.

## Timing
- All outputs are registered.
- Latency: if the last row of a block is accepted on edge t, column 0 appears with o_valid = 1 after edge t+1. Columns 1..N-1 follow on consecutive cycles.
- A continuous same-size stream never overflows: writing a block takes ≥ N cycles and draining it takes exactly N.
- Overflow is possible only when a small block follows a large one while both banks are occupied. Example: N=4 blocks arriving back-to-back while a 32×32 block drains.
- o_transize and o_inverse change only together with o_valid, at the column-0 edge of each block.

## Test plan
- 4×4 block, rows r with value 16·r + c in lane c, i_transize = 0 → 4 o_valid cycles starting 1 cycle after the last row. Column c shows o_k = 16·k + c for k < 4, o_4..o_31 = 0, o_transize = 0.
- 32×32 block, row r lane c = 32·r + c, then an immediate second 32×32 block → two 32-cycle drains. The second drain follows the first with no gap. Every sample is transposed exactly; o_err = 0.
- 32×32 block followed by three back-to-back 4×4 blocks → the first 4×4 block is buffered and drains right after the 32×32 block. Rows of the third block arriving while both banks are occupied are dropped and o_err = 1 is held. Rows arriving after a bank returns to EMPTY are accepted.
- i_transize toggled from 1 to 3 and i_inverse toggled between rows 2 and 3 of an 8×8 block → output is 8 columns with o_transize = 1 and the inverse value sampled at row 0.
- rst asserted after 5 rows of a 16×16 block, then a fresh 8×8 block is written → o_valid = 0 and all outputs = 0 during reset. Exactly 8 columns of the new block are emitted, with no stale data.
- Full-scale values −32768 and 32767 in alternating lanes of a 16×16 block → bit-exact transposed output with signs preserved.
